// File: rtl/iomem_dma.sv
// iomem word-copy DMA: CPU-programmed responder registers plus an initiator port that copies CNT words SRC->DST.
// Optional macro IOMEM_DMA_IRQ_EN adds a level irq output and a CTRL/STAT bit3 irq mask.
module iomem_dma #(
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
`ifdef IOMEM_DMA_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP, S_WR, S_DONE} state_t;

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    state_t             state, state_n;
    logic [31:0]        src, dst;
    logic [CNT_W-1:0]   cnt, cnt_dec;
    logic               done, aborted, abort_pend, busy;
    logic               req, wr_en, wr_ctrl, start_go, mask_bit;
    logic [1:0]         sel;
    logic [31:0]        rd_mux, src_m, dst_m, cnt_m;
    logic               addr_unused;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int unsigned b = 0; b < 4; b++)
            if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    assign addr_unused = &{1'b0, iomem_addr[31:4], iomem_addr[1:0]};

    assign sel      = iomem_addr[3:2];
    assign req      = iomem_valid && !iomem_ready;
    assign wr_en    = req && (iomem_wstrb != 4'b0000);
    assign wr_ctrl  = wr_en && (sel == 2'd3);
    assign busy     = (state != S_IDLE);
    assign start_go = wr_ctrl && iomem_wdata[0] && !busy;
    assign cnt_dec  = cnt - CNT_W'(1);

    assign src_m = merge(src, iomem_wdata, iomem_wstrb);
    assign dst_m = merge(dst, iomem_wdata, iomem_wstrb);
    assign cnt_m = merge(32'(cnt), iomem_wdata, iomem_wstrb);

`ifdef IOMEM_DMA_IRQ_EN
    logic irq_mask;
    assign mask_bit = irq_mask;
    // Level irq: visible from the DONE cycle until done is cleared (clear-done or new start)
    assign irq = !irq_mask && (done || state == S_DONE);
`else
    assign mask_bit = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (sel)
            2'd0:    rd_mux = src;
            2'd1:    rd_mux = dst;
            2'd2:    rd_mux = 32'(cnt);
            default: rd_mux = {28'b0, mask_bit, aborted, done, busy};
        endcase
    end

    assign m_valid = (state == S_RD) || (state == S_WR);
    assign m_addr  = (state == S_WR) ? dst : ((state == S_RD) ? src : '0);
    assign m_wstrb = (state == S_WR) ? 4'hF : 4'h0;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start_go && cnt != '0) state_n = S_RD;
            S_RD:   if (m_ready) state_n = S_GAP;
            S_GAP:  state_n = S_WR;
            S_WR:   if (m_ready) state_n = (cnt_dec == '0 || abort_pend) ? S_DONE : S_RD;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            m_wdata     <= '0;
            src         <= '0;
            dst         <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            abort_pend  <= 1'b0;
`ifdef IOMEM_DMA_IRQ_EN
            irq_mask    <= 1'b0;
`endif
        end else begin
            // Ack is a one-cycle pulse; the cycle after it always reads ready=0
            iomem_ready <= req;
            if (req) iomem_rdata <= rd_mux;
            if (wr_en && !busy) begin
                case (sel)
                    2'd0:    src <= src_m;
                    2'd1:    dst <= dst_m;
                    2'd2:    cnt <= cnt_m[CNT_W-1:0];
                    default: ;
                endcase
            end
            if (wr_ctrl) begin
                if (iomem_wdata[2]) done <= 1'b0;
`ifdef IOMEM_DMA_IRQ_EN
                irq_mask <= iomem_wdata[3];
`endif
                if (iomem_wdata[1] && busy) abort_pend <= 1'b1;
                if (start_go) begin
                    done       <= (cnt == '0);
                    aborted    <= 1'b0;
                    abort_pend <= 1'b0;
                end
            end
            if (state == S_RD && m_ready) m_wdata <= m_rdata;
            if (state == S_WR && m_ready) begin
                src <= src + STEP;
                dst <= dst + STEP;
                cnt <= cnt_dec;
            end
            if (state == S_DONE) begin
                done       <= 1'b1;
                abort_pend <= 1'b0;
                if (abort_pend) aborted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iomem_dma.sv
// Self-checking bench for iomem_dma: register table, then multi-cycle DMA sequences against a wait-state target model.
module tb_iomem_dma;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
`ifdef IOMEM_DMA_IRQ_EN
    logic        irq;
`endif

    iomem_dma #(.ADDR_STEP(4), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef IOMEM_DMA_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          wait_cycles = 1;
    logic        hold_wr = 1'b0;
    int          wcnt = 0;
    int          rd_idx = 0;
    int          vcount = 0;
    int          nlog = 0;
    logic [31:0] log_addr[64];
    logic [3:0]  log_strb[64];
    logic [31:0] log_data[64];
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_strb;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Target model: ready after wait_cycles, read data 0x11*(n+1), logs every handshake
    always @(negedge clk) begin
        if (resetn && prev_valid && !prev_ready && !m_valid) begin
            checks++; errors++;
            $display("FAIL valid_drop: m_valid fell without m_ready");
        end
        m_ready = 1'b0;
        if (!resetn || !m_valid) begin
            wcnt = 0;
        end else begin
            vcount++;
            if (wcnt == 0) begin
                h_addr = m_addr; h_strb = m_wstrb; h_data = m_wdata;
            end else begin
                checks++;
                if (m_addr !== h_addr || m_wstrb !== h_strb || m_wdata !== h_data) begin
                    errors++;
                    $display("FAIL stable: addr %h strb %h data %h, held %h %h %h",
                             m_addr, m_wstrb, m_wdata, h_addr, h_strb, h_data);
                end
            end
            if (wcnt >= wait_cycles && !(hold_wr && m_wstrb != 4'h0)) begin
                m_ready = 1'b1;
                if (m_wstrb == 4'h0) begin
                    m_rdata = 32'h11 * 32'(rd_idx + 1);
                    rd_idx++;
                end
                if (nlog < 64) begin
                    log_addr[nlog] = m_addr; log_strb[nlog] = m_wstrb; log_data[nlog] = m_wdata;
                    nlog++;
                end
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
        prev_valid = resetn && m_valid;
        prev_ready = m_ready;
    end

    task automatic bus(input logic [1:0] sel, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd);
        int n;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0900_0000 | {28'b0, sel, 2'b00};
        iomem_wdata = wd;
        iomem_wstrb = ws;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!iomem_ready && n < 20);
        if (!iomem_ready) begin
            checks++; errors++;
            $display("FAIL bus_timeout: no iomem_ready within 20 cycles");
        end
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] wd);
        logic [31:0] d;
        bus(sel, wd, 4'hF, d);
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] sel, input logic [31:0] exp);
        logic [31:0] d;
        bus(sel, '0, 4'h0, d);
        chk(nm, d, exp);
    endtask

    task automatic wait_done();
        logic [31:0] d;
        int n;
        n = 0;
        do begin
            bus(2'd3, '0, 4'h0, d);
            n++;
        end while (d[0] && n < 300);
        if (d[0]) begin
            checks++; errors++;
            $display("FAIL done_timeout: still busy after 300 polls");
        end
    endtask

    task automatic clr_log();
        nlog = 0; rd_idx = 0; vcount = 0;
    endtask

    typedef struct {
        logic        is_wr;
        logic [1:0]  sel;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[17];

    initial begin
        logic [31:0] d;
        int n;

        vt[0]  = '{1'b0, 2'd3, 32'h0,        4'h0, 32'h0};
        vt[1]  = '{1'b0, 2'd0, 32'h0,        4'h0, 32'h0};
        vt[2]  = '{1'b0, 2'd2, 32'h0,        4'h0, 32'h0};
        vt[3]  = '{1'b1, 2'd0, 32'h12345678, 4'hF, 32'h0};
        vt[4]  = '{1'b0, 2'd0, 32'h0,        4'h0, 32'h12345678};
        vt[5]  = '{1'b1, 2'd0, 32'hAABBCCDD, 4'h5, 32'h0};
        vt[6]  = '{1'b0, 2'd0, 32'h0,        4'h0, 32'h12BB56DD};
        vt[7]  = '{1'b1, 2'd1, 32'hCAFEF00D, 4'hF, 32'h0};
        vt[8]  = '{1'b0, 2'd1, 32'h0,        4'h0, 32'hCAFEF00D};
        vt[9]  = '{1'b1, 2'd2, 32'hFFFF1234, 4'hF, 32'h0};
        vt[10] = '{1'b0, 2'd2, 32'h0,        4'h0, 32'h00001234};
        vt[11] = '{1'b1, 2'd2, 32'h0000AB00, 4'h2, 32'h0};
        vt[12] = '{1'b0, 2'd2, 32'h0,        4'h0, 32'h0000AB34};
        vt[13] = '{1'b1, 2'd3, 32'h00000002, 4'hF, 32'h0};
        vt[14] = '{1'b0, 2'd3, 32'h0,        4'h0, 32'h0};
        vt[15] = '{1'b1, 2'd3, 32'h00000004, 4'hF, 32'h0};
        vt[16] = '{1'b0, 2'd3, 32'h0,        4'h0, 32'h0};

        repeat (3) @(negedge clk);
        chk("rst_iomem_ready", 32'(iomem_ready), 32'h0);
        chk("rst_iomem_rdata", iomem_rdata, 32'h0);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wstrb", 32'(m_wstrb), 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        @(posedge clk); #1 resetn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            bus(vt[i].sel, vt[i].wdata, vt[i].wstrb, d);
            if (!vt[i].is_wr) chk($sformatf("table[%0d]", i), d, vt[i].exp);
        end

        // Three-word copy, target ready one cycle after valid
        clr_log(); wait_cycles = 1;
        wr(2'd0, 32'h0300_0000); wr(2'd1, 32'h0500_0000); wr(2'd2, 32'd3); wr(2'd3, 32'h1);
        wait_done();
        chk("copy3_nlog", 32'(nlog), 32'd6);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("copy3_rd%0d_addr", k), log_addr[2*k], 32'h0300_0000 + 32'(4*k));
            chk($sformatf("copy3_rd%0d_strb", k), 32'(log_strb[2*k]), 32'h0);
            chk($sformatf("copy3_wr%0d_addr", k), log_addr[2*k+1], 32'h0500_0000 + 32'(4*k));
            chk($sformatf("copy3_wr%0d_strb", k), 32'(log_strb[2*k+1]), 32'hF);
            chk($sformatf("copy3_wr%0d_data", k), log_data[2*k+1], 32'h11 * 32'(k + 1));
        end
        rd_chk("copy3_stat", 2'd3, 32'h2);
`ifdef IOMEM_DMA_IRQ_EN
        chk("copy3_irq", 32'(irq), 32'h1);
`endif

        // CNT=0 start: done without bus traffic
        wr(2'd3, 32'h4);
        rd_chk("clrdone_stat", 2'd3, 32'h0);
`ifdef IOMEM_DMA_IRQ_EN
        chk("clrdone_irq", 32'(irq), 32'h0);
`endif
        clr_log();
        wr(2'd2, 32'd0); wr(2'd3, 32'h1);
        rd_chk("cnt0_stat", 2'd3, 32'h2);
        repeat (4) @(negedge clk);
        chk("cnt0_no_valid", 32'(vcount), 32'h0);

        // Four words with 5 wait cycles per beat; stability checked by the target model
        clr_log(); wait_cycles = 5;
        wr(2'd0, 32'h0000_0100); wr(2'd1, 32'h0000_0200); wr(2'd2, 32'd4); wr(2'd3, 32'h5);
        wait_done();
        chk("wait_nlog", 32'(nlog), 32'd8);
        chk("wait_wr3_data", log_data[7], 32'h44);
        chk("wait_wr3_addr", log_addr[7], 32'h0000_020C);
        rd_chk("wait_cnt", 2'd2, 32'h0);
        rd_chk("wait_src", 2'd0, 32'h0000_0110);
        rd_chk("wait_dst", 2'd1, 32'h0000_0210);
        rd_chk("wait_stat", 2'd3, 32'h2);

        // Abort during the second read beat
        clr_log(); wait_cycles = 4;
        wr(2'd0, 32'h0000_1000); wr(2'd1, 32'h0000_2000); wr(2'd2, 32'd10); wr(2'd3, 32'h1);
        n = 0;
        while (!(rd_idx == 1 && m_valid && m_wstrb == 4'h0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_rd2", 32'(n < 200), 32'h1);
        wr(2'd3, 32'h2);
        wait_done();
        chk("abort_nlog", 32'(nlog), 32'd4);
        chk("abort_reads", 32'(rd_idx), 32'd2);
        chk("abort_wr1_data", log_data[3], 32'h22);
        rd_chk("abort_stat", 2'd3, 32'h6);
        rd_chk("abort_cnt", 2'd2, 32'd8);

        // Address wrap at the top of the 32-bit space
        clr_log(); wait_cycles = 1;
        wr(2'd0, 32'hFFFF_FFFC); wr(2'd1, 32'h0000_0300); wr(2'd2, 32'd2); wr(2'd3, 32'h1);
        wait_done();
        chk("wrap_rd0_addr", log_addr[0], 32'hFFFF_FFFC);
        chk("wrap_rd1_addr", log_addr[2], 32'h0000_0000);
        rd_chk("wrap_src", 2'd0, 32'h0000_0004);
        rd_chk("wrap_stat", 2'd3, 32'h2);

        // Reset mid-WR with the target stalling
        clr_log(); wait_cycles = 1; hold_wr = 1'b1;
        wr(2'd0, 32'h0000_0040); wr(2'd1, 32'h0000_0080); wr(2'd2, 32'd5); wr(2'd3, 32'h1);
        n = 0;
        while (!(m_valid && m_wstrb == 4'hF) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_wr", 32'(n < 100), 32'h1);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", 32'(m_valid), 32'h0);
        chk("midrst_m_addr", m_addr, 32'h0);
        chk("midrst_m_wdata", m_wdata, 32'h0);
`ifdef IOMEM_DMA_IRQ_EN
        chk("midrst_irq", 32'(irq), 32'h0);
`endif
        @(posedge clk); #1 resetn = 1'b1;
        hold_wr = 1'b0;
        rd_chk("midrst_src", 2'd0, 32'h0);
        rd_chk("midrst_dst", 2'd1, 32'h0);
        rd_chk("midrst_cnt", 2'd2, 32'h0);
        rd_chk("midrst_stat", 2'd3, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
